// File: rtl/seq_mult_ctrl.sv
// Sequential signed shift-add multiplier controller driving an external 2N-bit adder ALU.
// Magnitudes are multiplied unsigned, then the sign is applied through one extra ALU pass.
//
// state   | meaning
// st_idle | waiting for start; ALU operands forced to zero
// st_calc | N shift-add iterations, acc += mcand when mplier lsb is set
// st_fix  | two's-complement sign fix of acc, result captured into product
// st_done | one-cycle done pulse
module seq_mult_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [2*N-1:0] alu_a,
  output logic [2*N-1:0] alu_p,
  input  logic [2*N-1:0] alu_result,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  one_n    = 1;
  localparam logic [W-1:0]  one_w    = 1;
  localparam logic [CW-1:0] cnt_one  = 1;
  localparam logic [CW-1:0] cnt_last = CW'(N - 1);

  typedef enum logic [1:0] {st_idle, st_calc, st_fix, st_done} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   acc, mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           sign;
  logic [N-1:0]   abs_a, abs_b;

  // the most negative operand maps to 2^(N-1), which still fits unsigned
  assign abs_a = op_a[N-1] ? (~op_a + one_n) : op_a;
  assign abs_b = op_b[N-1] ? (~op_b + one_n) : op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_p    = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      st_idle: if (start) state_nx = st_calc;
      st_calc: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_p = mcand;
        if (cnt == cnt_last) state_nx = st_fix;
      end
      st_fix: begin
        busy     = 1'b1;
        alu_a    = sign ? ~acc : acc;
        alu_p    = sign ? one_w : '0;
        state_nx = st_done;
      end
      st_done: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = st_idle;
      end
      default: state_nx = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        st_idle: if (start) begin
          sign    <= op_a[N-1] ^ op_b[N-1];
          mcand   <= {{N{1'b0}}, abs_a};
          mplier  <= abs_b;
          acc     <= '0;
          cnt     <= '0;
          product <= '0;
        end
        st_calc: begin
          if (mplier[0]) acc <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + cnt_one;
        end
        st_fix:  product <= alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: an arithmetic phase model checked every cycle,
// plus literal products and latencies pinned per vector.
module tb_seq_mult_ctrl;
  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] alu_a, alu_p, alu_result, product;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  seq_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a), .alu_p(alu_p), .alu_result(alu_result),
    .busy(busy), .done(done), .product(product)
  );

  // downstream adder ALU
  assign alu_result = alu_a + alu_p;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1..N calc iteration (phase-1), N+1 fix, N+2 done
  int                  m_phase = 0;
  logic signed [N-1:0] m_a = '0, m_b = '0;
  logic [W-1:0]        m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_prod  = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a = op_a; m_b = op_b; m_prod = '0; m_phase = 1;
      end
    end else if (m_phase == N + 2) begin
      m_phase = 0;
    end else begin
      if (m_phase == N + 1) m_prod = W'(int'(m_a) * int'(m_b));
      m_phase++;
    end
  end

  always @(negedge clk) begin
    int aa, bb, i;
    logic [W-1:0] ea, ep, mag;
    logic sgn;
    aa  = m_a[N-1] ? -int'(m_a) : int'(m_a);
    bb  = m_b[N-1] ? -int'(m_b) : int'(m_b);
    sgn = m_a[N-1] ^ m_b[N-1];
    ea  = '0;
    ep  = '0;
    if (m_phase >= 1 && m_phase <= N) begin
      i  = m_phase - 1;
      ea = W'(aa * (bb % (1 << i)));
      ep = W'(aa << i);
    end else if (m_phase == N + 1) begin
      mag = W'(aa * bb);
      ea  = sgn ? ~mag : mag;
      ep  = sgn ? W'(1) : W'(0);
    end
    chk("busy", W'(busy), W'(m_phase != 0));
    chk("done", W'(done), W'(m_phase == N + 2));
    chk("product", product, m_prod);
    chk("alu_a", alu_a, ea);
    chk("alu_p", alu_p, ep);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic [W-1:0] p; } vec_t;
  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{8'hFD, 8'hFB, 16'h000F};
    vecs[3] = '{8'h80, 8'h80, 16'h4000};
    vecs[4] = '{8'h7F, 8'h80, 16'hC080};
    vecs[5] = '{8'h00, 8'hF9, 16'h0000};

    #12;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_product", product, W'(0));
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[v]) begin
      launch(vecs[v].a, vecs[v].b);
      wait_done(k);
      chk("latency", W'(k), W'(N + 1));
      chk("vec_product", product, vecs[v].p);
      chk("model_pin", m_prod, vecs[v].p);
      step();
      chk("hold_product", product, vecs[v].p);
      chk("idle_busy", W'(busy), W'(0));
      step();
    end

    // restart attempt mid-calc must be ignored
    launch(8'h03, 8'h05);
    step(); step();
    op_a = 8'h07; op_b = 8'h07; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(k);
    chk("ignore_latency", W'(k), W'(N - 2));
    chk("ignore_product", product, 16'h000F);
    step(); step(); step();
    chk("ignore_no_restart", W'(busy), W'(0));
    chk("ignore_product_hold", product, 16'h000F);

    // start held through done: accepted on the first idle edge
    op_a = 8'h02; op_b = 8'h03; start = 1'b1;
    step();
    wait_done(k);
    chk("held_latency", W'(k), W'(N + 1));
    chk("held_product", product, 16'h0006);
    op_a = 8'h04; op_b = 8'h05;
    step();
    chk("held_idle", W'(busy), W'(0));
    step();
    chk("held_accept", W'(busy), W'(1));
    chk("held_cleared", product, W'(0));
    start = 1'b0;
    wait_done(k);
    chk("held2_latency", W'(k), W'(N + 1));
    chk("held2_product", product, 16'h0014);
    step();

    // async reset mid-calc
    launch(8'hF9, 8'h06);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_product", product, W'(0));
    step();
    rst_n = 1'b1;
    step();
    launch(8'hF9, 8'h06);
    wait_done(k);
    chk("post_rst_latency", W'(k), W'(N + 1));
    chk("post_rst_product", product, 16'hFFD6);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
